// File: rtl/blink_pkg.sv
// Shared types for the blink/tick generator.
//   blink_mode_t : per-channel operating mode (OFF, TOGGLE, PULSE, ONESHOT)
//   os_state_t   : one-shot sequencing state (idle / running)
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_TOGGLE  = 2'd1,
        MODE_PULSE   = 2'd2,
        MODE_ONESHOT = 2'd3
    } blink_mode_t;

    typedef enum logic {
        OsIdle = 1'b0,
        OsRun  = 1'b1
    } os_state_t;

endpackage

// File: rtl/blink_tick_gen_channel.sv
// One blink/tick channel: programmable terminal count, mode, and one-shot sequencer.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   enable            : count enable
//   sync              : phase-align strobe (affects TOGGLE/PULSE only)
//   we                : config write for this channel
//   new_mode/new_term : config data
//   wave, tick, busy  : registered outputs
module blink_channel
    import blink_pkg::*;
#(
    parameter int unsigned      CNT_W    = 26,
    parameter logic [CNT_W-1:0] DEF_TERM = CNT_W'(26'h2600000),
    parameter blink_mode_t      DEF_MODE = MODE_TOGGLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             we,
    input  blink_mode_t      new_mode,
    input  logic [CNT_W-1:0] new_term,
    output logic             wave,
    output logic             tick,
    output logic             busy
);

    logic [CNT_W-1:0] term_q, term_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    blink_mode_t      mode_q, mode_d;
    os_state_t        state_q, state_d;
    logic             wave_q, wave_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             hit;

    assign hit = enable && (cnt_q == term_q);

    always_comb begin
        term_d  = term_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        wave_d  = wave_q;
        busy_d  = busy_q;
        tick_d  = 1'b0;

        if (we) begin
            // A write always restarts the channel, even on a terminal cycle.
            term_d  = new_term;
            mode_d  = new_mode;
            cnt_d   = '0;
            wave_d  = (new_mode == MODE_ONESHOT);
            busy_d  = (new_mode == MODE_ONESHOT);
            state_d = (new_mode == MODE_ONESHOT) ? OsRun : OsIdle;
        end else begin
            case (mode_q)
                MODE_TOGGLE, MODE_PULSE: begin
                    busy_d  = 1'b0;
                    state_d = OsIdle;
                    if (sync) begin
                        cnt_d  = '0;
                        wave_d = 1'b0;
                    end else if (hit) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        wave_d = (mode_q == MODE_TOGGLE) ? ~wave_q : 1'b1;
                    end else begin
                        if (enable) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        // PULSE wave mirrors tick, so it drops on any non-terminal cycle.
                        if (mode_q == MODE_PULSE) begin
                            wave_d = 1'b0;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (state_q == OsRun) begin
                        if (hit) begin
                            state_d = OsIdle;
                            cnt_d   = '0;
                            wave_d  = 1'b0;
                            busy_d  = 1'b0;
                            tick_d  = 1'b1;
                        end else if (enable) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d  = '0;
                        wave_d = 1'b0;
                        busy_d = 1'b0;
                    end
                end
                default: begin // MODE_OFF
                    cnt_d   = '0;
                    wave_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = OsIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            term_q  <= DEF_TERM;
            mode_q  <= DEF_MODE;
            cnt_q   <= '0;
            state_q <= OsIdle;
            wave_q  <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            term_q  <= term_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            wave_q  <= wave_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign wave = wave_q;
    assign tick = tick_q;
    assign busy = busy_q;

endmodule

// File: rtl/blink_tick_gen.sv
// Multi-channel blink/tick generator for the clock-adjust UI.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   enable     : global count enable, fanned out to all channels
//   sync       : phase-align strobe for all TOGGLE/PULSE channels
//   cfg_we     : config write strobe; cfg_ch selects channel, out-of-range ignored
//   cfg_mode   : 0 OFF, 1 TOGGLE, 2 PULSE, 3 ONESHOT
//   cfg_term   : terminal count value
//   wave/tick/busy : per-channel registered outputs
module blink_tick_gen
    import blink_pkg::*;
#(
    parameter int unsigned      CNT_W    = 26,
    parameter int unsigned      N_CH     = 4,
    parameter logic [CNT_W-1:0] DEF_TERM = CNT_W'(26'h2600000),
    parameter blink_mode_t      DEF_MODE = MODE_TOGGLE,
    localparam int unsigned     CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_term,
    output logic [N_CH-1:0]  wave,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  busy
);

    logic [N_CH-1:0] ch_we;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // cfg_ch values >= N_CH match no channel, so such writes are dropped.
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        blink_channel #(
            .CNT_W    (CNT_W),
            .DEF_TERM (DEF_TERM),
            .DEF_MODE (DEF_MODE)
        ) u_channel (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .sync     (sync),
            .we       (ch_we[i]),
            .new_mode (blink_mode_t'(cfg_mode)),
            .new_term (cfg_term),
            .wave     (wave[i]),
            .tick     (tick[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: doc/blink_tick_gen.md
# blink_tick_gen

Parametrised multi-channel blink/tick generator for the VGA clock-adjust path. Each channel counts enabled clock cycles up to a run-time programmable terminal value and produces either a toggling blink, a periodic single-cycle pulse, or a one-shot window. It drives the digit-blink and auto-repeat timing of the time-setting UI from one block.

## Interface
- CNT_W, 26, counter and terminal-value width
- N_CH, 4, number of independent channels (≥1)
- DEF_TERM, 26'h2600000, terminal value loaded into every channel at reset
- DEF_MODE, MODE_TOGGLE, mode loaded into every channel at reset
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global count enable; counters advance only when high
- sync  in  1  single-cycle phase-align strobe for all periodic channels
- cfg_we  in  1  config write strobe
- cfg_ch  in  max(1,$clog2(N_CH))  target channel of write
- cfg_mode  in  2  new mode: 0 OFF, 1 TOGGLE, 2 PULSE, 3 ONESHOT
- cfg_term  in  CNT_W  new terminal value
- wave  out  N_CH  per-channel waveform
- tick  out  N_CH  per-channel single-cycle terminal pulse
- busy  out  N_CH  per-channel one-shot in progress

## Operation
- Per channel: registers term, mode, cnt (CNT_W), wave, tick, busy.
- Terminal event: enable=1 and cnt==term. On it cnt←0 and tick←1; otherwise, when enable=1, cnt←cnt+1. enable=0: cnt, wave, busy held; tick←0.
- OFF: cnt held 0; wave, tick, busy = 0.
- TOGGLE: wave inverts on each terminal event; half-period = term+1 enabled cycles.
- PULSE: wave←1 for exactly the cycle tick is high; period term+1 enabled cycles.
- ONESHOT states IDLE/RUN. Write with ONESHOT → RUN: cnt←0, wave←1, busy←1. In RUN, terminal event → IDLE: wave←0, busy←0, tick←1 once. IDLE holds cnt 0, no further ticks until rewritten.
- term=0: TOGGLE inverts every enabled cycle; PULSE holds wave/tick high every enabled cycle; ONESHOT runs 1 enabled cycle.
- Config write (cfg_we=1, cfg_ch<N_CH): loads term/mode, cnt←0, tick←0, wave←0 (ONESHOT: wave←1, busy←1). cfg_ch≥N_CH ignored.
- sync=1: every TOGGLE/PULSE channel cnt←0, wave←0, tick←0; OFF and ONESHOT channels unaffected.
- Priority per channel: reset > config write > sync > terminal event/count. Write coinciding with terminal event: write wins, no tick, no toggle.
- Counter arithmetic modulo 2^CNT_W; term lowered below current cnt by write is safe since write clears cnt.

## Timing
- All outputs registered; no combinational input-to-output path.
- Reset values: cnt 0, wave 0, tick 0, busy 0, term DEF_TERM, mode DEF_MODE, ONESHOT state IDLE.
- Reset mid-operation: all outputs 0 on the following cycle, config reverts to defaults.
- After reset deassert with enable=1 continuously, TOGGLE channel first inverts wave on the edge where cnt==term, i.e. term+1 edges after the first enabled edge; tick high in the same cycle wave changes.
- Config write and sync take effect at the next clk edge; counting resumes the cycle after.
- tick width exactly 1 cycle except term=0 continuous case.

## Structure
- Package blink_pkg: mode constants MODE_OFF/TOGGLE/PULSE/ONESHOT (2-bit typedef blink_mode_t), ONESHOT state constants.
- Sub-module blink_channel (one channel: cnt, term, mode, state, outputs), instantiated N_CH times by a generate loop; top decodes cfg_ch into per-channel write strobes and fans out enable/sync.

## Test plan
Bench parameters CNT_W=4, N_CH=4, DEF_TERM=3, DEF_MODE=TOGGLE.
- Reset, then enable=1 steady → all wave bits rise after 4 edges, invert every 4 cycles; tick 1-cycle high on each inversion.
- enable low 2 cycles mid-count (cnt=1) → next inversion delayed exactly 2 cycles; tick never high while enable low.
- Write ch1 PULSE term=1 → wave[1]=tick[1] high every 2nd cycle; write ch2 PULSE term=0 → wave[2] constantly high.
- Write ch3 ONESHOT term=5 → busy[3]/wave[3] high 6 enabled cycles, then low with single tick[3]; stays idle 20 cycles; rewrite restarts it.
- Write ch0 on the cycle cnt==term → no tick/toggle, cnt 0; sync with ch0 TOGGLE and ch3 ONESHOT running → ch0 wave 0, cnt 0; ch3 unaffected; cfg_ch=5 equivalent ignored (N_CH=4 uses cfg_ch 2 bits, so test with N_CH=3 build: cfg_ch=3 ignored).
- Assert reset mid-run after term writes → next cycle all outputs 0, periods back to 4 cycles.
